// File: rtl/ln_vec_packer.sv
// Serial-to-parallel packer in front of the LayerNorm mean tree: collects up to
// N_LANES samples, freezes them while the tree drains, then presents vector+mean.
module ln_vec_packer #(
    parameter int N_LANES  = 16,
    parameter int DATA_W   = 16,
    parameter int TREE_LAT = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_W-1:0]                  s_data,
    input  logic                               s_last,
    output logic [N_LANES*DATA_W-1:0]          x_out_flat,
    input  logic [DATA_W-1:0]                  mean_in,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [N_LANES*DATA_W-1:0]          m_vec,
    output logic [DATA_W-1:0]                  m_mean,
    output logic [$clog2(N_LANES+1)-1:0]       m_count
);

    localparam int CNT_W  = $clog2(N_LANES);
    localparam int MC_W   = $clog2(N_LANES + 1);
    localparam int WAIT_W = $clog2(TREE_LAT + 1);
    localparam int VEC_W  = N_LANES * DATA_W;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [VEC_W-1:0]    lanes_r;
    logic [DATA_W-1:0]   m_mean_r;
    logic [MC_W-1:0]     m_count_r;
    logic                m_valid_r;
    logic                s_ready_r;

    logic                beat_s;
    logic                close_s;
    logic                capture_s;
    logic                release_s;
    logic                last_lane_s;

    assign last_lane_s = (cnt_r == CNT_W'(N_LANES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode from the per-state control strobes
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (close_s) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_WAIT: begin
                if (capture_s) begin
                    state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (release_s) begin
                    state_nx_s = ST_FILL;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_FILL;
            end
        endcase
    end

    // Control strobes; only registered inputs qualify handshakes, so no input-to-output path
    always_comb begin
        beat_s    = 1'b0;
        close_s   = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                beat_s = s_valid & s_ready_r;
                if (s_valid && s_ready_r && (last_lane_s || s_last)) begin
                    close_s = 1'b1;
                end else begin
                    close_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_W'(0)) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (m_valid_r && m_ready) begin
                    release_s = 1'b1;
                end else begin
                    release_s = 1'b0;
                end
            end
            default: begin
                beat_s = 1'b0;
            end
        endcase
    end

    // Lane write pointer and tree drain countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= CNT_W'(0);
            wait_cnt_r <= WAIT_W'(0);
        end else begin
            if (release_s) begin
                cnt_r <= CNT_W'(0);
            end else if (beat_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (close_s) begin
                wait_cnt_r <= WAIT_W'(TREE_LAT);
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_W'(0))) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end
        end
    end

    // Lane buffer: written only in FILL, cleared on result hand-off so short vectors are zero-padded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_r <= {VEC_W{1'b0}};
        end else if (release_s) begin
            lanes_r <= {VEC_W{1'b0}};
        end else if (beat_s) begin
            for (int k = 0; k < N_LANES; k++) begin
                if (cnt_r == CNT_W'(k)) begin
                    lanes_r[k*DATA_W +: DATA_W] <= s_data;
                end
            end
        end
    end

    // Result registers and input-ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mean_r  <= {DATA_W{1'b0}};
            m_count_r <= MC_W'(0);
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b0;
        end else begin
            if (close_s) begin
                m_count_r <= MC_W'(cnt_r) + MC_W'(1);
            end
            if (capture_s) begin
                m_mean_r <= mean_in;
            end
            if (capture_s) begin
                m_valid_r <= 1'b1;
            end else if (release_s) begin
                m_valid_r <= 1'b0;
            end
            s_ready_r <= (state_nx_s == ST_FILL);
        end
    end

    assign s_ready    = s_ready_r;
    assign x_out_flat = lanes_r;
    assign m_vec      = lanes_r;
    assign m_mean     = m_mean_r;
    assign m_count    = m_count_r;
    assign m_valid    = m_valid_r;

endmodule

// File: tb/tb_ln_vec_packer.sv
// Directed bench for ln_vec_packer with a 5-stage mean-tree model feeding mean_in.
module tb_ln_vec_packer;

    localparam int VW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;
    logic          s_last;
    logic [255:0]  x_out_flat;
    logic [15:0]   mean_in;
    logic          m_valid;
    logic          m_ready;
    logic [255:0]  m_vec;
    logic [15:0]   m_mean;
    logic [4:0]    m_count;

    int errors = 0;
    int checks = 0;

    logic [15:0]   tree_pipe [5];
    logic [255:0]  exp_vec;
    logic [255:0]  held_vec;
    logic [15:0]   held_mean;
    logic [4:0]    held_count;
    int            lat;

    always #5 clk = ~clk;

    ln_vec_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .x_out_flat (x_out_flat),
        .mean_in    (mean_in),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_vec      (m_vec),
        .m_mean     (m_mean),
        .m_count    (m_count)
    );

    // Mean tree: signed sum of 16 lanes divided by 16, five register stages
    function automatic logic [15:0] tree_mean(input logic [255:0] v);
        int sum;
        sum = 0;
        for (int k = 0; k < 16; k++) begin
            sum += int'($signed(v[k*16 +: 16]));
        end
        return 16'(sum >>> 4);
    endfunction

    always @(posedge clk) begin
        tree_pipe[0] <= tree_mean(x_out_flat);
        for (int i = 1; i < 5; i++) begin
            tree_pipe[i] <= tree_pipe[i-1];
        end
    end
    assign mean_in = tree_pipe[4];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        check("s_ready_fill", VW'(s_ready), VW'(1'b1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(output int latency);
        latency = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check("s_ready_wait", VW'(s_ready), VW'(1'b0));
            if (m_valid === 1'b1) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic expect_result(input logic [15:0] mean_e, input logic [4:0] count_e,
                                 input logic [255:0] vec_e);
        check("m_valid", VW'(m_valid), VW'(1'b1));
        check("m_mean", VW'(m_mean), VW'(mean_e));
        check("m_count", VW'(m_count), VW'(count_e));
        check("m_vec", m_vec, vec_e);
        check("x_out_flat", x_out_flat, vec_e);
    endtask

    task automatic expect_release();
        @(posedge clk);
        #1;
        check("rel_m_valid", VW'(m_valid), VW'(1'b0));
        check("rel_s_ready", VW'(s_ready), VW'(1'b1));
        check("rel_cleared", x_out_flat, VW'(1'b0));
    endtask

    task automatic expect_all_zero(input string tag);
        check({tag, "_m_valid"}, VW'(m_valid), VW'(1'b0));
        check({tag, "_s_ready"}, VW'(s_ready), VW'(1'b0));
        check({tag, "_x_out"}, x_out_flat, VW'(1'b0));
        check({tag, "_m_vec"}, m_vec, VW'(1'b0));
        check({tag, "_m_mean"}, VW'(m_mean), VW'(1'b0));
        check({tag, "_m_count"}, VW'(m_count), VW'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #2;
        expect_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check("s_ready_in_reset", VW'(s_ready), VW'(1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", VW'(s_ready), VW'(1'b1));

        // Full uniform vector of 1.0
        for (int k = 0; k < 16; k++) send(16'h0100, 1'b0);
        wait_result(lat);
        check("latency_uniform", VW'(lat), VW'(6));
        exp_vec = '0;
        for (int k = 0; k < 16; k++) exp_vec[k*16 +: 16] = 16'h0100;
        expect_result(16'h0100, 5'd16, exp_vec);
        expect_release();

        // Ramp 0.0 .. 15.0
        exp_vec = '0;
        for (int k = 0; k < 16; k++) begin
            send(16'(k << 8), 1'b0);
            exp_vec[k*16 +: 16] = 16'(k << 8);
        end
        wait_result(lat);
        check("latency_ramp", VW'(lat), VW'(6));
        expect_result(16'h0780, 5'd16, exp_vec);
        expect_release();

        // Partial vector closed by s_last on the fourth beat
        exp_vec = '0;
        for (int k = 0; k < 4; k++) begin
            send(16'h1000, k == 3);
            exp_vec[k*16 +: 16] = 16'h1000;
        end
        wait_result(lat);
        check("latency_partial", VW'(lat), VW'(6));
        expect_result(16'h0400, 5'd4, exp_vec);
        expect_release();

        // Max value with redundant s_last on lane 15, then downstream backpressure
        m_ready = 1'b0;
        exp_vec = '0;
        for (int k = 0; k < 16; k++) begin
            send(16'h7FFF, k == 15);
            exp_vec[k*16 +: 16] = 16'h7FFF;
        end
        wait_result(lat);
        check("latency_max", VW'(lat), VW'(6));
        expect_result(16'h7FFF, 5'd16, exp_vec);
        held_vec   = m_vec;
        held_mean  = m_mean;
        held_count = m_count;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        s_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp_m_valid", VW'(m_valid), VW'(1'b1));
            check("bp_s_ready", VW'(s_ready), VW'(1'b0));
            check("bp_m_vec", m_vec, held_vec);
            check("bp_m_mean", VW'(m_mean), VW'(held_mean));
            check("bp_m_count", VW'(m_count), VW'(held_count));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        expect_release();

        // Reset asserted three cycles into WAIT
        for (int k = 0; k < 16; k++) send(16'h0200, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all_zero("rst_wait");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("rst_no_m_valid", VW'(m_valid), VW'(1'b0));
        end
        check("s_ready_after_rst2", VW'(s_ready), VW'(1'b1));

        // Fresh vector after reset: alternating -1.0 and 3.0 averages to 1.0
        exp_vec = '0;
        for (int k = 0; k < 16; k++) begin
            send((k % 2 == 1) ? 16'h0300 : 16'hFF00, 1'b0);
            exp_vec[k*16 +: 16] = (k % 2 == 1) ? 16'h0300 : 16'hFF00;
        end
        wait_result(lat);
        check("latency_post_rst", VW'(lat), VW'(6));
        expect_result(16'h0100, 5'd16, exp_vec);
        expect_release();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
